// File: rtl/bitonic_sorter_pkg.sv
// Shared candidate type, FSM encoding and pt ordering helper for the top-k sorter.
package bitonic_sorter_pkg;
  localparam int PT_WIDTH  = 8;
  localparam int IDX_WIDTH = 4;

  typedef struct packed {
    logic [PT_WIDTH-1:0]  pt;
    logic [IDX_WIDTH-1:0] idx;
  } muon_t;

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} sort_state_t;

  // Strict ordering only: equal pt is never "better", so ties stay in arrival order.
  function automatic logic pt_better(input muon_t a, input muon_t b, input logic desc);
    return desc ? (a.pt > b.pt) : (a.pt < b.pt);
  endfunction
endpackage

// File: rtl/topk_insert_cell.sv
// One slot of the systolic insertion list: decides whether this slot keeps its
// entry, takes the new candidate, or takes its left neighbour's entry.
module topk_insert_cell
  import bitonic_sorter_pkg::*;
#(
  parameter bit DIR = 1'b1
) (
  input  muon_t cand,
  input  muon_t own,
  input  logic  own_valid,
  input  muon_t left,
  input  logic  left_valid,
  input  logic  left_keep,
  output logic  keep,
  output muon_t nxt,
  output logic  nxt_valid
);
  // keep is a prefix over the sorted list; the first non-keep slot receives the candidate.
  always_comb begin
    keep      = own_valid && !pt_better(cand, own, DIR);
    nxt       = own;
    nxt_valid = own_valid;
    if (!keep) begin
      if (left_keep) begin
        nxt       = cand;
        nxt_valid = 1'b1;
      end else begin
        nxt       = left;
        nxt_valid = left_valid;
      end
    end
  end
endmodule

// File: rtl/streaming_topk_sorter.sv
// Streaming top-k sorter: inserts one candidate per cycle into a sorted register
// list during FILL, then streams the retained entries head-first during DRAIN.
module streaming_topk_sorter
  import bitonic_sorter_pkg::*;
#(
  parameter int TOP_K  = 8,
  parameter int DIR    = 1,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  muon_t             in_muon,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output muon_t             out_muon,
  output logic              out_last,
  output logic [DROP_W-1:0] dropped
);
  localparam int CW = $clog2(TOP_K + 1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  sort_state_t             state, state_nxt;
  muon_t [TOP_K-1:0]       list, ins_e;
  logic  [TOP_K-1:0]       vld, ins_v;
  logic  [TOP_K:0]         keep;
  logic  [CW-1:0]          cnt;
  logic                    accept, out_xfer;

  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign keep[0]  = 1'b1;

  generate
    for (genvar i = 0; i < TOP_K; i++) begin : g_cell
      muon_t left_e;
      logic  left_v;
      if (i == 0) begin : g_head
        assign left_e = '0;
        assign left_v = 1'b0;
      end else begin : g_body
        assign left_e = list[i-1];
        assign left_v = vld[i-1];
      end
      topk_insert_cell #(.DIR(DIR != 0)) u_cell (
        .cand      (in_muon),
        .own       (list[i]),
        .own_valid (vld[i]),
        .left      (left_e),
        .left_valid(left_v),
        .left_keep (keep[i]),
        .keep      (keep[i+1]),
        .nxt       (ins_e[i]),
        .nxt_valid (ins_v[i])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_muon  = '0;
    case (state)
      FILL: begin
        in_ready = rst_n;
        if (accept && in_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_muon  = list[0];
        out_last  = (cnt == CW'(1));
        if (out_xfer && out_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // List, occupancy and drop counter. A full list drops exactly one entry per
  // accept (either the candidate or the displaced tail). Draining shifts zeros in,
  // so the list is empty again once the last entry leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list    <= '0;
      vld     <= '0;
      cnt     <= '0;
      dropped <= '0;
    end else if (state == FILL && accept) begin
      if (!keep[TOP_K]) begin
        list <= ins_e;
        vld  <= ins_v;
      end
      if (cnt == '0)
        dropped <= '0;
      else if (cnt == CW'(TOP_K) && dropped != DROP_MAX)
        dropped <= dropped + DROP_W'(1);
      if (cnt != CW'(TOP_K)) cnt <= cnt + CW'(1);
    end else if (state == DRAIN && out_xfer) begin
      list <= {muon_t'('0), list[TOP_K-1:1]};
      vld  <= {1'b0, vld[TOP_K-1:1]};
      cnt  <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_streaming_topk_sorter.sv
// Directed bench: three sorter configurations (desc k=4, asc k=4, desc k=2 with a
// 2-bit drop counter) driven and sampled on the falling clock edge.
module tb_streaming_topk_sorter;
  import bitonic_sorter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic  iv[3], il[3], ordy[3], ir[3], ov[3], ol[3];
  muon_t im[3], om[3];
  logic [7:0] drp0, drp1;
  logic [1:0] drp2;

  int n_chk = 0;
  int n_fail = 0;
  int stim[8];
  int ep[8];
  int ei[8];

  streaming_topk_sorter #(.TOP_K(4), .DIR(1), .DROP_W(8)) u_desc (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_muon(im[0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_muon(om[0]),
    .out_last(ol[0]), .dropped(drp0));

  streaming_topk_sorter #(.TOP_K(4), .DIR(0), .DROP_W(8)) u_asc (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_muon(im[1]),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_muon(om[1]),
    .out_last(ol[1]), .dropped(drp1));

  streaming_topk_sorter #(.TOP_K(2), .DIR(1), .DROP_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_muon(im[2]),
    .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_muon(om[2]),
    .out_last(ol[2]), .dropped(drp2));

  function automatic int drop_of(input int d);
    return (d == 0) ? int'(drp0) : (d == 1) ? int'(drp1) : int'(drp2);
  endfunction

  // Stream stim[0..n-1] back to back, idx = arrival position; ends on the cycle after the last accept.
  task automatic send_frame(input int d, input int n, input bit fin);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      n_chk++;
      if (ir[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL in_ready_fill dut%0d cand%0d: got %b want 1", d, k, ir[d]);
      end
      iv[d] = 1'b1;
      im[d].pt = PT_WIDTH'(stim[k]);
      im[d].idx = IDX_WIDTH'(k);
      il[d] = fin && (k == n - 1);
    end
    @(negedge clk);
    iv[d] = 1'b0;
    il[d] = 1'b0;
    n_chk++;
    if (ov[d] !== fin) begin
      n_fail++;
      $display("FAIL first_out_latency dut%0d: out_valid got %b want %b", d, ov[d], fin);
    end
  endtask

  // Drain n entries with out_ready held high, checking each against ep/ei.
  task automatic drain(input int d, input int n);
    ordy[d] = 1'b1;
    for (int k = 0; k < n; k++) begin
      n_chk++;
      if (ov[d] !== 1'b1 || om[d].pt !== PT_WIDTH'(ep[k]) || om[d].idx !== IDX_WIDTH'(ei[k]) ||
          ol[d] !== (k == n - 1) || ir[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_entry dut%0d #%0d: got v=%b pt=%0d idx=%0d last=%b rdy=%b want v=1 pt=%0d idx=%0d last=%b rdy=0",
                 d, k, ov[d], om[d].pt, om[d].idx, ol[d], ir[d], ep[k], ei[k], (k == n - 1));
      end
      @(negedge clk);
    end
    ordy[d] = 1'b0;
    n_chk++;
    if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end dut%0d: got out_valid=%b in_ready=%b want 0/1", d, ov[d], ir[d]);
    end
  endtask

  task automatic check_drop(input int d, input int exp, input string nm);
    n_chk++;
    if (drop_of(d) !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: dropped got %0d want %0d", nm, d, drop_of(d), exp);
    end
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (ov[d] !== 1'b0 || ol[d] !== 1'b0 || om[d] !== '0 || ir[d] !== 1'b0 || drop_of(d) !== 0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got v=%b last=%b muon=%h rdy=%b drop=%0d want all 0",
                 d, ov[d], ol[d], om[d], ir[d], drop_of(d));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (ir[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_ready dut%0d: got %b want 1", d, ir[d]);
      end
    end
  endtask

  task automatic test_desc_ties();
    stim = '{3, 9, 1, 7, 5, 9, 0, 0};
    ep   = '{9, 9, 7, 5, 0, 0, 0, 0};
    ei   = '{1, 5, 3, 4, 0, 0, 0, 0};
    send_frame(0, 6, 1'b1);
    check_drop(0, 2, "desc_drop_in_drain");
    drain(0, 4);
    check_drop(0, 2, "desc_drop_hold");
  endtask

  task automatic test_short_frame();
    stim = '{6, 2, 0, 0, 0, 0, 0, 0};
    ep   = '{6, 2, 0, 0, 0, 0, 0, 0};
    ei   = '{0, 1, 0, 0, 0, 0, 0, 0};
    send_frame(0, 2, 1'b1);
    check_drop(0, 0, "short_drop_cleared");
    drain(0, 2);
  endtask

  task automatic test_single();
    stim = '{42, 0, 0, 0, 0, 0, 0, 0};
    ep   = '{42, 0, 0, 0, 0, 0, 0, 0};
    ei   = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(0, 1, 1'b1);
    drain(0, 1);
  endtask

  task automatic test_ascending();
    stim = '{8, 4, 6, 2, 9, 0, 0, 0};
    ep   = '{2, 4, 6, 8, 0, 0, 0, 0};
    ei   = '{3, 1, 2, 0, 0, 0, 0, 0};
    send_frame(1, 5, 1'b1);
    check_drop(1, 1, "asc_drop");
    drain(1, 4);
  endtask

  task automatic test_backpressure();
    int pat[5];
    int hp[5];
    int hl[5];
    pat = '{1, 0, 0, 1, 1};
    hp  = '{8, 4, 4, 4, 2};
    hl  = '{0, 0, 0, 0, 1};
    stim = '{4, 8, 2, 0, 0, 0, 0, 0};
    send_frame(0, 3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      ordy[0] = pat[c][0];
      n_chk++;
      if (ov[0] !== 1'b1 || om[0].pt !== PT_WIDTH'(hp[c]) || ol[0] !== hl[c][0] || ir[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure cycle%0d: got v=%b pt=%0d last=%b rdy=%b want v=1 pt=%0d last=%0d rdy=0",
                 c, ov[0], om[0].pt, ol[0], ir[0], hp[c], hl[c]);
      end
      @(negedge clk);
    end
    ordy[0] = 1'b0;
    n_chk++;
    if (ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_end: out_valid got %b want 0", ov[0]);
    end
  endtask

  task automatic test_saturate();
    stim = '{1, 2, 3, 4, 5, 6, 7, 0};
    ep   = '{7, 6, 0, 0, 0, 0, 0, 0};
    ei   = '{6, 5, 0, 0, 0, 0, 0, 0};
    send_frame(2, 7, 1'b1);
    check_drop(2, 3, "drop_saturate");
    drain(2, 2);
  endtask

  task automatic test_reset_mid();
    stim = '{10, 20, 30, 40, 50, 0, 0, 0};
    send_frame(0, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b0 || drp0 !== 8'd0 || drp1 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got rdy=%b v=%b drop0=%0d drop1=%0d want 0/0/0/0", ir[0], ov[0], drp0, drp1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_release: got v=%b rdy=%b want 0/1", ov[0], ir[0]);
    end
    stim = '{5, 1, 4, 2, 3, 0, 0, 0};
    ep   = '{5, 4, 3, 2, 0, 0, 0, 0};
    ei   = '{0, 2, 4, 3, 0, 0, 0, 0};
    send_frame(0, 5, 1'b1);
    check_drop(0, 1, "post_reset_drop");
    drain(0, 4);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      il[d] = 1'b0;
      ordy[d] = 1'b0;
      im[d] = '0;
    end
    test_reset();
    test_desc_ties();
    test_short_frame();
    test_single();
    test_ascending();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/streaming_topk_sorter.md
STREAMING_TOPK_SORTER -- requirements
Module: streaming_topk_sorter

Interface
REQ-001 SHALL have parameter TOP_K, default 8, number of retained candidates per frame (2..64).
REQ-002 SHALL have parameter DIR, default 1; 1 = descending pt, 0 = ascending pt.
REQ-003 SHALL have parameter DROP_W, default 8, width of dropped-candidate counter.
REQ-004 SHALL have port clk  input  1  logic clock; single clock domain, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  candidate present.
REQ-007 SHALL have port in_ready  output  1  block accepts candidate.
REQ-008 SHALL have port in_muon  input  muon_t  candidate (pt, idx).
REQ-009 SHALL have port in_last  input  1  final candidate of frame.
REQ-010 SHALL have port out_valid  output  1  sorted candidate present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts.
REQ-012 SHALL have port out_muon  output  muon_t  sorted candidate.
REQ-013 SHALL have port out_last  output  1  final sorted candidate of frame.
REQ-014 SHALL have port dropped  output  DROP_W  candidates discarded in current/last frame, saturating.

Function
REQ-015 SHALL accept a candidate on cycles where in_valid and in_ready are both 1; transfer on out side when out_valid and out_ready are both 1.
REQ-016 SHALL implement states FILL and DRAIN; reset enters FILL.
REQ-017 FILL: in_ready = 1, out_valid = 0; each accepted candidate inserted in one cycle into a TOP_K register list kept sorted per DIR.
REQ-018 Insertion SHALL be stable: new candidate placed after all entries with equal pt; when list full and new pt not strictly better than last entry, candidate discarded.
REQ-019 When list full and candidate inserted, displaced last entry SHALL be discarded.
REQ-020 Each discard SHALL increment dropped by 1, saturating at 2**DROP_W-1.
REQ-021 Accepting a candidate with in_last = 1 SHALL transition to DRAIN on next edge; out_valid = 1 in the first cycle after that accept.
REQ-022 DRAIN: in_ready = 0; out_muon = list head; each out transfer shifts list by one; out_valid stays 1 while retained entries remain; out_valid, out_muon, out_last SHALL hold while out_ready = 0.
REQ-023 Number emitted SHALL equal min(frame candidate count, TOP_K); out_last = 1 only on final emitted entry.
REQ-024 Out transfer with out_last = 1 SHALL return to FILL next cycle with list empty; dropped cleared at first accept of next frame (holds value during DRAIN and idle FILL).
REQ-025 Frame of exactly 1 candidate SHALL emit one entry with out_last = 1.
REQ-026 Throughput: one candidate per cycle in FILL, one per cycle in DRAIN with out_ready held 1; frame latency last-accept to first out = 1 cycle.
REQ-027 pt comparisons unsigned, width PT_WIDTH; idx carried unmodified.

Reset
REQ-028 rst_n low SHALL asynchronously force: state FILL, list empty, in_ready = 1 after release, out_valid = 0, out_last = 0, out_muon = 0, dropped = 0.
REQ-029 Reset mid-FILL or mid-DRAIN SHALL abandon the frame; no partial output after release.
REQ-030 in_ready SHALL be 0 while rst_n is low.

Structure
REQ-031 muon_t, PT_WIDTH, IDX_WIDTH SHALL come from bitonic_sorter_pkg; no local redefinition.
REQ-032 Per-slot compare/insert logic SHALL be one sub-module, topk_insert_cell, instantiated TOP_K times in a generate loop (systolic: each cell sees its own entry, left neighbour, new candidate).
REQ-033 Entry-count register width SHALL be $clog2(TOP_K+1).

Verification
REQ-034 TOP_K=4, DIR=1: pts 3,9,1,7,5,9(last) -> out pts 9,9,7,5; idx of first 9 precedes second; out_last on 4th; dropped=2.
REQ-035 TOP_K=4: 2 candidates pts 6,2(last) -> out 6,2, out_last on 2; dropped=0.
REQ-036 DIR=0, TOP_K=4: pts 8,4,6,2,9(last) -> out 2,4,6,8; dropped=1.
REQ-037 Backpressure: out_ready toggled 1,0,0,1 in DRAIN -> out_muon stable across stalls, no loss or duplication; in_ready=0 throughout DRAIN.
REQ-038 rst_n pulsed low after 3rd of 5 candidates -> out_valid=0, dropped=0; next full frame sorts correctly with no stale entries.
REQ-039 DROP_W=2, TOP_K=2: 7 distinct ascending pts in one frame -> dropped saturates at 3; out = two largest.
